seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit 7-segment driver.
- Watches the seg/an/dp lines the driver produces, waits for each digit to be stable, decodes the segment pattern back to a hex nibble, and rebuilds the 16-bit displayed value.
- Used for on-chip loopback checking of the display path and as a self-checking monitor in display benches.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical samples of {an,seg,dp} needed before a digit is accepted (1..255).
- TIMEOUT, 1048576, cycles without a completed frame before timeout asserts (≥ 16).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg  input  7  segment lines {g,f,e,d,c,b,a}, active-low
- an  input  4  digit anodes, active-low; an[0] = least significant digit
- dp  input  1  decimal point, active-low
- value  output  16  last complete reconstructed value; digit i in value[4i+3:4i]
- valid  output  1  one-cycle pulse when value updates
- dp_mask  output  4  dp state per digit captured with value (1 = dp lit)
- digit_err  output  1  one-cycle pulse: stable one-hot anode with undecodable segment pattern
- timeout  output  1  level; high while no frame has completed for TIMEOUT cycles

Behaviour:
- Reset: value=0, dp_mask=0, valid=0, digit_err=0, timeout=0, seen mask=0, stability count=0, FSM=SETTLING, timeout counter=0. Reset mid-frame discards all partial digits.
- Input stage: {an,seg,dp} registered once into smp. No synchronizer; inputs are same-clock or quasi-static.
- Stability counter: if smp equals the previous smp, increment, saturating at SETTLE_CYCLES. Otherwise clear to 0 and force FSM=SETTLING.
- FSM:
  - SETTLING: count reaches SETTLE_CYCLES → evaluate the sample, go to HELD.
  - HELD: stay until smp changes, then go to SETTLING. This gives exactly one evaluation per stable window, however long it lasts.
- Evaluation:
  - an all ones (blank): ignored.
  - More than one anode low: ignored, no error.
  - Exactly one anode low, pattern decodable: store nibble in slot i, store dp bit, set seen[i]. A repeat of the same digit overwrites the slot.
  - Exactly one anode low, pattern undecodable: digit_err pulses next cycle, seen[i] unchanged.
- Decode table (seg, active-low), giving 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110. Every other pattern is undecodable.
- Frame completion:
  - When seen becomes 4'b1111, on the next edge: value/dp_mask load from the slots, valid pulses for 1 cycle, seen clears.
  - An evaluation in that same cycle lands in the freshly cleared mask; it is not lost.
- Latency: E0 is the first edge that registers a new stable input.
  - Slot write at edge E0+SETTLE_CYCLES.
  - valid/value at edge E0+SETTLE_CYCLES+1 when this is the fourth digit.
- Timeout:
  - Counter increments every cycle, clears when valid pulses, saturates at TIMEOUT.
  - timeout is high whenever the counter equals TIMEOUT and drops on the cycle valid pulses.
- value holds between frames and is never changed by errors or timeout.

Decomposition:
- Package seg7_pkg holds:
  - the 16 segment-pattern constants (shared with the driver);
  - the digit-count constant (4);
  - a decode function returning {ok, nibble}.
- One natural sub-module: seg7_decode, combinational, seg[6:0] → nibble[3:0] + ok. It is reused by the driver's bench.
- FSM, counters and slot registers stay in seg7_capture.

Test Plan:
- Drive each digit in turn for 8 cycles (an=1110 seg=0110000 "3", an=1101 "2"=0100100, an=1011 "1"=1111001, an=0111 "0"=1000000), SETTLE_CYCLES=4 → valid pulses once, value=16'h0123, dp_mask=0.
- Glitch: an=1110 with "5" held only 3 cycles, then "7" held 8 cycles, plus other three digits → value[3:0]=7; "5" is never captured.
- Undecodable: an=1110 seg=1111111 held 8 cycles → digit_err single pulse 5 cycles after the first sample; no valid while the remaining digits are valid.
- Blank and multi-anode: an=1111 or an=1100 held 100 cycles → no valid, no digit_err, seen unchanged.
- Reset mid-frame: capture 3 digits, assert reset for 1 cycle, drive only digit 3 → no valid; outputs at reset values.
- Timeout/loopback:
  - TIMEOUT=64 with idle inputs → timeout rises at cycle 64.
  - Then connect the display driver with sw=16'hBEEF → valid with value=16'hBEEF, and timeout falls in the same cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and decode helper for the multiplexed 4-digit 7-segment display path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

   localparam int unsigned NumDigits = 4;

   localparam logic [6:0] SegPatterns [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic [0:0] {
      StSettling,
      StHeld
   } cap_state_e;

   typedef struct packed {
      logic       ok;
      logic [3:0] nibble;
   } decode_t;

   function automatic decode_t seg7_decode_fn(input logic [6:0] seg);
      decode_t res;
      res = '0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SegPatterns[i]) begin
            res.ok     = 1'b1;
            res.nibble = 4'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Display lines plus reconstructed-value outputs of the segment capture block.
// master drives the display lines; slave is the capture side.
interface seg7_capture_if;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic [15:0] value;
   logic        valid;
   logic [3:0]  dp_mask;
   logic        digit_err;
   logic        timeout;

   modport master (
      output seg, an, dp,
      input  value, valid, dp_mask, digit_err, timeout
   );

   modport slave (
      input  seg, an, dp,
      output value, valid, dp_mask, digit_err, timeout
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to hex-nibble decoder; ok is low for unknown patterns.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       ok
);

   decode_t res;

   always_comb begin
      res    = seg7_decode_fn(seg);
      nibble = res.nibble;
      ok     = res.ok;
   end

endmodule

// File: rtl/seg7_capture.sv
// Watches multiplexed seg/an/dp lines, accepts each digit once it is stable and rebuilds
// the displayed 16-bit value, with per-digit error and frame timeout reporting.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned TIMEOUT       = 1048576
) (
   input logic           clk,
   input logic           reset,
   seg7_capture_if.slave bus
);

   localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    SettleMax  = 8'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT);

   // Sample layout: {an[3:0], seg[6:0], dp}
   logic [11:0] smp_in, smp_q;
   logic        same;
   logic [7:0]  cnt_d, cnt_q;

   cap_state_e  state_d, state_q;
   logic        eval;

   logic [3:0]  an_low;
   logic        one_hot;
   logic [3:0]  dec_nibble;
   logic        dec_ok;
   logic        eval_ok, eval_bad;

   logic [15:0] slots_d, slots_q;
   logic [3:0]  dp_slots_d, dp_slots_q;
   logic [3:0]  seen_d, seen_q;
   logic        frame_done;

   logic [15:0] value_q;
   logic [3:0]  dp_mask_q;
   logic        valid_q;
   logic        err_q;
   logic [TW-1:0] tcnt_d, tcnt_q;

   assign smp_in = {bus.an, bus.seg, bus.dp};
   assign same   = (smp_in == smp_q);

   always_comb begin
      cnt_d = 8'd0;
      if (same) begin
         cnt_d = (cnt_q == SettleMax) ? cnt_q : cnt_q + 8'd1;
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StSettling;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (!same) begin
         state_d = StSettling;
      end else if (state_q == StSettling && cnt_d == SettleMax) begin
         state_d = StHeld;
      end
   end

   // FSM: outputs; one evaluation per stable window
   always_comb begin
      eval = 1'b0;
      if (state_q == StSettling && same && cnt_d == SettleMax) begin
         eval = 1'b1;
      end
   end

   seg7_decode u_decode (
      .seg    (smp_q[7:1]),
      .nibble (dec_nibble),
      .ok     (dec_ok)
   );

   assign an_low   = ~smp_q[11:8];
   assign one_hot  = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
   assign eval_ok  = eval && one_hot && dec_ok;
   assign eval_bad = eval && one_hot && !dec_ok;

   assign frame_done = (seen_q == 4'hF);

   // A digit accepted on the completion edge lands in the freshly cleared mask.
   always_comb begin
      slots_d    = slots_q;
      dp_slots_d = dp_slots_q;
      seen_d     = frame_done ? 4'd0 : seen_q;
      if (eval_ok) begin
         for (int i = 0; i < NumDigits; i++) begin
            if (an_low[i]) begin
               slots_d[4*i +: 4] = dec_nibble;
               dp_slots_d[i]     = ~smp_q[0];
               seen_d[i]         = 1'b1;
            end
         end
      end
   end

   always_comb begin
      tcnt_d = tcnt_q;
      if (frame_done) begin
         tcnt_d = '0;
      end else if (tcnt_q != TimeoutMax) begin
         tcnt_d = tcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         smp_q      <= '1;
         cnt_q      <= 8'd0;
         slots_q    <= 16'd0;
         dp_slots_q <= 4'd0;
         seen_q     <= 4'd0;
         value_q    <= 16'd0;
         dp_mask_q  <= 4'd0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         tcnt_q     <= '0;
      end else begin
         smp_q      <= smp_in;
         cnt_q      <= cnt_d;
         slots_q    <= slots_d;
         dp_slots_q <= dp_slots_d;
         seen_q     <= seen_d;
         valid_q    <= frame_done;
         err_q      <= eval_bad;
         tcnt_q     <= tcnt_d;
         if (frame_done) begin
            value_q   <= slots_q;
            dp_mask_q <= dp_slots_q;
         end
      end
   end

   assign bus.value     = value_q;
   assign bus.dp_mask   = dp_mask_q;
   assign bus.valid     = valid_q;
   assign bus.digit_err = err_q;
   assign bus.timeout   = (tcnt_q == TimeoutMax);

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: expected frames go into a scoreboard queue and are
// checked when valid pulses; latency, error, reset and timeout points are checked inline.
module tb_seg7_capture;

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  m;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   int   valid_cnt = 0;
   int   err_cnt = 0;
   exp_t sb[$];

   logic [6:0] pat [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   seg7_capture_if bus ();

   seg7_capture #(
      .SETTLE_CYCLES (4),
      .TIMEOUT       (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] an, input logic [6:0] seg, input logic dp);
      bus.an  = an;
      bus.seg = seg;
      bus.dp  = dp;
   endtask

   task automatic digit(input int d, input logic [3:0] nib, input logic dp_lit, input int n);
      logic [3:0] one;
      one = 4'b0001 << d;
      set_in(~one, pat[nib], ~dp_lit);
      cycles(n);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_value"}, 32'(bus.value), 32'h0);
      chk({tag, "_dp_mask"}, 32'(bus.dp_mask), 32'h0);
      chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
      chk({tag, "_digit_err"}, 32'(bus.digit_err), 32'h0);
      chk({tag, "_timeout"}, 32'(bus.timeout), 32'h0);
   endtask

   // Scoreboard side: every valid pulse pops one expected frame.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (bus.digit_err === 1'b1) err_cnt++;
      if (bus.valid === 1'b1) begin
         valid_cnt++;
         chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("frame_value", 32'(bus.value), 32'(e.v));
            chk("frame_dp_mask", 32'(bus.dp_mask), 32'(e.m));
         end
      end
   end

   initial begin
      logic [15:0] sw;
      logic        prev_to;
      logic        got;
      logic [3:0]  one;

      set_in(4'b1111, 7'b1111111, 1'b1);
      cycles(2);
      reset = 1'b0;
      chk_reset_state("reset");

      // Frame 0123 with exact valid latency on the last digit
      sb.push_back('{v: 16'h0123, m: 4'h0});
      digit(0, 4'h3, 1'b0, 8);
      digit(1, 4'h2, 1'b0, 8);
      digit(2, 4'h1, 1'b0, 8);
      digit(3, 4'h0, 1'b0, 5);
      chk("valid_early", 32'(bus.valid), 32'h0);
      cycles(1);
      chk("valid_on_time", 32'(bus.valid), 32'h1);
      chk("value_0123", 32'(bus.value), 32'h0123);
      cycles(1);
      chk("valid_one_cycle", 32'(bus.valid), 32'h0);
      cycles(1);
      chk("frames_after_0123", 32'(valid_cnt), 32'd1);

      // Short "5" glitch is never captured; dp lit on digit 2
      sb.push_back('{v: 16'h0127, m: 4'b0100});
      digit(0, 4'h5, 1'b0, 3);
      digit(0, 4'h7, 1'b0, 8);
      digit(1, 4'h2, 1'b0, 8);
      digit(2, 4'h1, 1'b1, 8);
      digit(3, 4'h0, 1'b0, 8);
      chk("frames_after_glitch", 32'(valid_cnt), 32'd2);

      // Blank and multi-anode windows leave the partial frame intact
      sb.push_back('{v: 16'hDCBA, m: 4'h0});
      digit(0, 4'hA, 1'b0, 8);
      digit(1, 4'hB, 1'b0, 8);
      digit(2, 4'hC, 1'b0, 8);
      set_in(4'b1111, pat[8], 1'b0);
      cycles(100);
      set_in(4'b1100, pat[8], 1'b1);
      cycles(100);
      chk("blank_no_valid", 32'(valid_cnt), 32'd2);
      chk("blank_no_err", 32'(err_cnt), 32'd0);
      digit(3, 4'hD, 1'b0, 8);
      chk("frames_after_blank", 32'(valid_cnt), 32'd3);

      // Undecodable pattern on digit 0
      set_in(4'b1110, 7'b1111111, 1'b1);
      cycles(4);
      chk("err_early", 32'(bus.digit_err), 32'h0);
      cycles(1);
      chk("err_pulse", 32'(bus.digit_err), 32'h1);
      cycles(1);
      chk("err_one_cycle", 32'(bus.digit_err), 32'h0);
      cycles(2);
      digit(1, 4'h1, 1'b0, 8);
      digit(2, 4'h2, 1'b0, 8);
      digit(3, 4'h3, 1'b0, 8);
      chk("undecodable_no_valid", 32'(valid_cnt), 32'd3);
      chk("undecodable_err_count", 32'(err_cnt), 32'd1);

      // Reset mid-frame discards partial digits
      do_reset();
      digit(0, 4'h4, 1'b0, 8);
      digit(1, 4'h5, 1'b0, 8);
      digit(2, 4'h6, 1'b0, 8);
      do_reset();
      chk_reset_state("midreset");
      digit(3, 4'h9, 1'b0, 16);
      chk("midreset_no_valid", 32'(valid_cnt), 32'd3);

      // Timeout from idle
      set_in(4'b1111, 7'b1111111, 1'b1);
      do_reset();
      cycles(63);
      chk("timeout_before", 32'(bus.timeout), 32'h0);
      cycles(1);
      chk("timeout_rise", 32'(bus.timeout), 32'h1);
      cycles(10);
      chk("timeout_held", 32'(bus.timeout), 32'h1);

      // Loopback of a driver showing BEEF; timeout falls with valid
      sw = 16'hBEEF;
      sb.push_back('{v: 16'hBEEF, m: 4'h0});
      prev_to = bus.timeout;
      got = 1'b0;
      for (int d = 0; d < 4; d++) begin
         one = 4'b0001 << d;
         bus.an  = ~one;
         bus.seg = pat[sw[4*d +: 4]];
         bus.dp  = 1'b1;
         for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1 && !got) begin
               got = 1'b1;
               chk("timeout_before_valid", 32'(prev_to), 32'h1);
               chk("timeout_at_valid", 32'(bus.timeout), 32'h0);
            end
            prev_to = bus.timeout;
         end
      end
      chk("loopback_valid", 32'(got), 32'h1);
      set_in(4'b1111, 7'b1111111, 1'b1);
      cycles(4);
      chk("value_holds", 32'(bus.value), 32'hBEEF);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("total_frames", 32'(valid_cnt), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
